spi_counter_master_tx: RTL and testbench
========================================

Name: spi_counter_master_tx

Overview:
- SPI mode-0 master that serializes a 14-bit counter value into one two-byte frame for the SPI slave counter display path.
- Frame content: high byte {2'b00, counter[13:8]}, then low byte counter[7:0], MSB first, with SS held low across both bytes.
- Sits on the counter-generating board and drives sclk/mosi/ss to the slave's pins.

Parameters:
- HALF_DIV, 50, clk cycles per SCLK half-period (100 MHz clk gives 1 MHz SCLK); legal minimum 2.
- SS_LEAD, 100, clk cycles from SS falling to the first SCLK rising-edge setup window.
- BYTE_GAP, 100, idle clk cycles with SCLK low between byte 0 and byte 1.
- SS_LAG, 100, clk cycles from the last SCLK falling edge to SS rising.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- i_counter  input  14  value to send; sampled when a start is accepted
- i_start  input  1  start request; accepted only in IDLE
- o_busy  output  1  high while a frame is in progress
- o_done  output  1  one-cycle pulse when a frame completes
- o_rx_data  output  16  MISO bits captured during the frame (see Optional Feature)
- sclk  output  1  SPI clock, idles low
- mosi  output  1  SPI data out
- miso  input  1  SPI data in
- ss  output  1  slave select, active low

Behaviour:
- Reset values: ss=1, sclk=0, mosi=0, o_busy=0, o_done=0, o_rx_data=0, state=IDLE.
- States: IDLE, LEAD, SHIFT, GAP, LAG, DONE.
- IDLE:
  - i_start=1 latches shreg = {2'b00, i_counter}.
  - Next cycle: ss=0, o_busy=1, state=LEAD.
- LEAD: stay SS_LEAD cycles, then go to SHIFT with bit index 7 and byte 0.
- SHIFT, per bit:
  - mosi = current MSB of the active byte, set at the start of the low phase.
  - sclk=0 for HALF_DIV cycles, then sclk=1 for HALF_DIV cycles.
  - miso is sampled on the cycle sclk rises.
  - sclk falls at the end of the high phase, then the next bit starts.
- After bit 0 of byte 0: sclk=0, state=GAP for BYTE_GAP cycles, then SHIFT for byte 1.
- After bit 0 of byte 1: sclk=0, state=LAG for SS_LAG cycles.
- DONE (1 cycle): ss=1, o_busy=0, o_done=1, mosi=0; then IDLE.
- Frame timing: ss low for exactly SS_LEAD + 32*HALF_DIV + BYTE_GAP + SS_LAG cycles (1900 with defaults). Exactly 16 sclk rising edges per frame.
- mosi is stable for HALF_DIV cycles on each side of every rising edge.
- i_start while busy: ignored, no queuing. i_counter changes mid-frame: no effect.
- i_start held high continuously: a new frame starts on the cycle after DONE (IDLE accepts it). Min ss-high time between frames is 2 cycles.
- Reset mid-frame: on the next clk edge, all outputs return to reset values, no o_done, partial frame abandoned.
- i_start asserted on the same cycle as reset: reset wins.

Optional Feature:
- Macro: SPI_MISO_RX_EN.
- Defined:
  - A 16-bit rx shift register captures miso (MSB first) on each sclk rising edge.
  - o_rx_data is updated with the full 16 bits on the DONE cycle and held until the next DONE or reset.
- Undefined:
  - No capture logic; o_rx_data is constant 0.
  - miso is unused. Ports are unchanged.

Test Plan:
- i_counter=1, start -> decoded mosi bytes 0x00, 0x01; o_done pulses once; ss low exactly 1900 cycles; 16 sclk rising edges.
- i_counter=1234 (0x04D2) -> bytes 0x04, 0xD2; SCLK high and low phases each exactly 50 cycles; gap of 100 cycles between byte 8th falling edge and next bit.
- i_counter=16383 -> bytes 0x3F, 0xFF. Connect to slave_top -> its o_counter=16383 after ss rises.
- i_start pulsed again mid-frame with i_counter=255 -> ignored; only the first frame is sent; a single o_done pulse.
- reset asserted at cycle 800 of a frame -> next cycle ss=1, sclk=0, o_busy=0; no o_done; a new start afterwards sends a correct full frame.
- SPI_MISO_RX_EN defined, miso driven with pattern 0xA55A aligned to the rising edges -> o_rx_data=0xA55A at o_done. Undefined -> o_rx_data stays 0.

Source files
------------

// File: rtl/spi_counter_master_tx.sv
// SPI mode-0 master that sends a 14-bit counter as one two-byte frame, MSB first.
// Optional MISO capture into o_rx_data is enabled by defining SPI_MISO_RX_EN.
module spi_counter_master_tx #(
  parameter int unsigned HALF_DIV = 50,
  parameter int unsigned SS_LEAD  = 100,
  parameter int unsigned BYTE_GAP = 100,
  parameter int unsigned SS_LAG   = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] i_counter,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rx_data,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, LAG, DONE} state_t;

  // One shared down-the-line counter serves every timed state, so size it for the longest.
  localparam int unsigned MAX_A = (HALF_DIV > SS_LEAD) ? HALF_DIV : SS_LEAD;
  localparam int unsigned MAX_B = (BYTE_GAP > SS_LAG) ? BYTE_GAP : SS_LAG;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] LEAD_LAST = CW'(SS_LEAD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] LAG_LAST  = CW'(SS_LAG - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          phase, phase_n;      // 0: sclk low half, 1: sclk high half
  logic [2:0]    bit_idx, bit_idx_n;
  logic          byte_idx, byte_idx_n;
  logic [15:0]   shreg, shreg_n;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= 1'b0;
      bit_idx  <= 3'd7;
      byte_idx <= 1'b0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phase    <= phase_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      shreg    <= shreg_n;
    end
  end

  // NOTE: every next-state signal is defaulted to its current value first, so no latches are inferred.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    phase_n    = phase;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shreg_n    = shreg;

    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_n = LEAD;
          cnt_n   = '0;
          shreg_n = {2'b00, i_counter};
        end
      end
      LEAD: begin
        if (cnt == LEAD_LAST) begin
          state_n    = SHIFT;
          cnt_n      = '0;
          phase_n    = 1'b0;
          bit_idx_n  = 3'd7;
          byte_idx_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
          end else begin
            // End of the high half: sclk falls and the next bit moves to the MSB.
            phase_n = 1'b0;
            shreg_n = {shreg[14:0], 1'b0};
            if (bit_idx == 3'd0) begin
              bit_idx_n = 3'd7;
              if (!byte_idx) begin
                state_n    = GAP;
                byte_idx_n = 1'b1;
              end else begin
                state_n = LAG;
              end
            end else begin
              bit_idx_n = bit_idx - 1'b1;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
          phase_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LAG: begin
        if (cnt == LAG_LAST) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_busy = (state == LEAD) || (state == SHIFT) || (state == GAP) || (state == LAG);
  assign ss     = ~o_busy;
  assign o_done = (state == DONE);
  assign sclk   = (state == SHIFT) && phase;
  assign mosi   = (state == SHIFT) && shreg[15];

`ifdef SPI_MISO_RX_EN
  logic [15:0] rx_sh;
  logic [15:0] rx_q;

  // Capture on the first cycle of each high half, i.e. the cycle sclk rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sh <= '0;
      rx_q  <= '0;
    end else begin
      if ((state == SHIFT) && phase && (cnt == '0))
        rx_sh <= {rx_sh[14:0], miso};
      if (state == DONE)
        rx_q <= rx_sh;
    end
  end

  assign o_rx_data = rx_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign o_rx_data   = '0;
`endif

endmodule

// File: tb/tb_spi_counter_master_tx.sv
// Directed bench for spi_counter_master_tx: decodes mosi, measures SPI timing, drives miso.
module tb_spi_counter_master_tx;

  localparam int HALF_DIV = 50;
  localparam int SS_LEAD  = 100;
  localparam int BYTE_GAP = 100;
  localparam int SS_LAG   = 100;
  localparam int FRAME_SS = SS_LEAD + 32 * HALF_DIV + BYTE_GAP + SS_LAG;

`ifdef SPI_MISO_RX_EN
  localparam logic [15:0] RX_EXP = 16'hA55A;
`else
  localparam logic [15:0] RX_EXP = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] i_counter = '0;
  logic        i_start = 1'b0;
  logic        o_busy, o_done, sclk, mosi, ss;
  logic [15:0] o_rx_data;
  logic        miso = 1'b0;

  spi_counter_master_tx #(
    .HALF_DIV(HALF_DIV), .SS_LEAD(SS_LEAD), .BYTE_GAP(BYTE_GAP), .SS_LAG(SS_LAG)
  ) dut (
    .clk(clk), .reset(reset), .i_counter(i_counter), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_rx_data(o_rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor state, cleared by the main thread between posedge and negedge.
  int          done_cnt, ss_low, rise_cnt, bad_phase, gap_low, last_ss_hi;
  int          sclk_run = 0, ss_run = 0, mosi_run = 0;
  logic [15:0] word;
  logic [15:0] rx_pat = 16'hA55A;
  logic        sclk_q = 1'b0, ss_q = 1'b1, mosi_q = 1'b0, mosi_at_rise = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (o_done) done_cnt++;
      if (!ss) ss_low++;
      if (ss == ss_q) ss_run++;
      else begin
        if (!ss) last_ss_hi = ss_run;
        ss_run = 1;
      end
      if (mosi == mosi_q) mosi_run++;
      else mosi_run = 1;
      if (sclk == sclk_q) sclk_run++;
      else begin
        if (sclk) begin
          rise_cnt++;
          word = {word[14:0], mosi};
          mosi_at_rise = mosi;
          if (mosi_run <= HALF_DIV) bad_phase++;
          if (rise_cnt == 9) gap_low = sclk_run;
          else if (rise_cnt >= 2 && sclk_run != HALF_DIV) bad_phase++;
        end else if (sclk_run != HALF_DIV) begin
          bad_phase++;
        end
        sclk_run = 1;
      end
      if (sclk && mosi != mosi_at_rise) bad_phase++;
      if (!sclk && rise_cnt < 16) miso = rx_pat[15 - rise_cnt];
      sclk_q = sclk;
      ss_q   = ss;
      mosi_q = mosi;
    end
  end

  task automatic clear_mon();
    done_cnt = 0; ss_low = 0; rise_cnt = 0; bad_phase = 0; gap_low = 0; word = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [13:0] value);
    i_counter = value;
    i_start   = 1'b1;
    tick(1);
    i_start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 4000) begin
      @(negedge clk);
      if (o_done) break;
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < 4000), 32'd1);
    tick(1);
  endtask

  initial begin
    tick(3);
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_rx", 32'(o_rx_data), 32'd0);
    reset = 1'b0;
    tick(2);

    // Frame 1: counter = 1
    clear_mon();
    pulse_start(14'd1);
    check("f1_busy", 32'(o_busy), 32'd1);
    wait_done("f1");
    check("f1_word", 32'(word), 32'h0001);
    check("f1_done_cnt", 32'(done_cnt), 32'd1);
    check("f1_ss_low", 32'(ss_low), 32'(FRAME_SS));
    check("f1_rises", 32'(rise_cnt), 32'd16);
    check("f1_idle", 32'(o_busy), 32'd0);

    // Frame 2: counter = 1234, phase and gap timing
    tick(5);
    clear_mon();
    pulse_start(14'd1234);
    wait_done("f2");
    check("f2_word", 32'(word), 32'h04D2);
    check("f2_bad_phase", 32'(bad_phase), 32'd0);
    check("f2_gap_low", 32'(gap_low), 32'(BYTE_GAP + HALF_DIV));
    check("f2_ss_low", 32'(ss_low), 32'(FRAME_SS));

    // Frame 3: counter = 16383 with a spurious start mid-frame, miso pattern driven
    tick(5);
    clear_mon();
    rx_pat = 16'hA55A;
    pulse_start(14'd16383);
    tick(500);
    pulse_start(14'd255);
    wait_done("f3");
    tick(20);
    check("f3_word", 32'(word), 32'h3FFF);
    check("f3_done_cnt", 32'(done_cnt), 32'd1);
    check("f3_rises", 32'(rise_cnt), 32'd16);
    check("f3_idle", 32'(o_busy), 32'd0);
    check("f3_rx", 32'(o_rx_data), 32'(RX_EXP));

    // Reset 800 cycles into a frame
    clear_mon();
    pulse_start(14'h1555);
    tick(799);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rstmid_ss", 32'(ss), 32'd1);
    check("rstmid_sclk", 32'(sclk), 32'd0);
    check("rstmid_busy", 32'(o_busy), 32'd0);
    check("rstmid_rx", 32'(o_rx_data), 32'd0);
    tick(2500);
    check("rstmid_no_done", 32'(done_cnt), 32'd0);
    clear_mon();
    pulse_start(14'h2AAA);
    wait_done("f4");
    check("f4_word", 32'(word), 32'h2AAA);
    check("f4_bad_phase", 32'(bad_phase), 32'd0);

    // Start held high: back-to-back frames with a 2-cycle ss-high gap
    tick(5);
    clear_mon();
    i_counter = 14'h0123;
    i_start   = 1'b1;
    wait_done("f5");
    tick(3);
    check("f5_restart_busy", 32'(o_busy), 32'd1);
    check("f5_ss_hi_gap", 32'(last_ss_hi), 32'd2);
    i_start = 1'b0;
    wait_done("f6");
    check("f6_done_cnt", 32'(done_cnt), 32'd2);

    // Start on the same cycle as reset
    tick(5);
    i_start = 1'b1;
    reset   = 1'b1;
    tick(1);
    check("rststart_busy", 32'(o_busy), 32'd0);
    check("rststart_ss", 32'(ss), 32'd1);
    i_start = 1'b0;
    reset   = 1'b0;
    tick(2);
    check("rststart_idle", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
